// File: rtl/op_issue_queue_if.sv
// Handshake and datapath bundle between the issue queue and its neighbours.
// The slave modport is the queue side; master is the requester/datapath side.
interface op_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [3:0]      in_a;
    logic [3:0]      in_b;
    logic [TAGW-1:0] in_tag;
    logic            issue_en;
    logic            flush;
    logic [7:0]      func_code;
    logic [3:0]      a_out;
    logic [3:0]      b_out;
    logic            parity_in;
    logic            res_valid;
    logic [TAGW-1:0] res_tag;
    logic            res_parity;
    logic [CW-1:0]   count;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, issue_en, flush, parity_in,
        output in_ready, func_code, a_out, b_out, res_valid, res_tag, res_parity, count
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, issue_en, flush, parity_in,
        input  in_ready, func_code, a_out, b_out, res_valid, res_tag, res_parity, count
    );
endinterface

// File: rtl/op_issue_queue.sv
// Issue queue for the 2-stage ALU/parity datapath: buffers requests in a
// small FIFO, issues one per cycle as a one-hot function code, and tracks
// the datapath latency so the returning parity can be paired with its tag.
module op_issue_queue #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int TAGW  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    op_issue_queue_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]      r_memOp  [DEPTH];
    logic [3:0]      r_memA   [DEPTH];
    logic [3:0]      r_memB   [DEPTH];
    logic [TAGW-1:0] r_memTag [DEPTH];

    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic [7:0]      r_funcCode;
    logic [3:0]      r_aOut;
    logic [3:0]      r_bOut;

    // r_issVld/r_issTag mark the issue register itself; r_vld/r_tag then
    // follow the request through the LAT datapath stages.
    logic            r_issVld;
    logic [TAGW-1:0] r_issTag;
    logic [LAT-1:0]  r_vld;
    logic [TAGW-1:0] r_tag [LAT];

    logic            w_full;
    logic            w_push;
    logic            w_pop;

    // Flush overrides both push and pop; an empty queue never pops, so a
    // new entry issues at the earliest on the edge after it was written.
    always_comb begin
        w_full = (r_count == CW'(DEPTH));
        w_push = bus.in_valid && !w_full && !bus.flush;
        w_pop  = (r_count != '0) && bus.issue_en && !bus.flush;
    end

    // Entry storage needs no reset; only entries covered by count are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memOp[r_wrPtr]  <= bus.in_op;
            r_memA[r_wrPtr]   <= bus.in_a;
            r_memB[r_wrPtr]   <= bus.in_b;
            r_memTag[r_wrPtr] <= bus.in_tag;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Issue register holds its last code when idle so the datapath never sees 8'h00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funcCode <= 8'h80;
            r_aOut     <= '0;
            r_bOut     <= '0;
        end else if (w_pop) begin
            r_funcCode <= 8'h80 >> r_memOp[r_rdPtr];
            r_aOut     <= r_memA[r_rdPtr];
            r_bOut     <= r_memB[r_rdPtr];
        end
    end

    // Valid/tag pipe shifts every edge regardless of issue_en; flush kills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issVld <= 1'b0;
            r_issTag <= '0;
            r_vld    <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else if (bus.flush) begin
            r_issVld <= 1'b0;
            r_vld    <= '0;
        end else begin
            r_issVld <= w_pop;
            r_issTag <= r_memTag[r_rdPtr];
            r_vld[0] <= r_issVld;
            r_tag[0] <= r_issTag;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.count      = r_count;
    assign bus.func_code  = r_funcCode;
    assign bus.a_out      = r_aOut;
    assign bus.b_out      = r_bOut;
    assign bus.res_valid  = r_vld[LAT-1];
    assign bus.res_tag    = r_tag[LAT-1];
    assign bus.res_parity = bus.parity_in && r_vld[LAT-1];

endmodule

// File: tb/tb_op_issue_queue.sv
// Directed bench for op_issue_queue with a behavioural 2-stage ALU/parity
// datapath supplying parity_in (odd parity of the 4-bit ALU result).
module tb_op_issue_queue;
    logic clk;
    logic rst_n;
    int   checkCount;
    int   failCount;

    op_issue_queue_if #(.DEPTH(4), .TAGW(4)) bus ();

    op_issue_queue #(.DEPTH(4), .LAT(2), .TAGW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [3:0] dpRes = 4'd0;
    logic       dpPar = 1'b0;

    function automatic logic [3:0] aluModel(input logic [7:0] fc, input logic [3:0] a, input logic [3:0] b);
        case (fc)
            8'h80:   return a + b;
            8'h40:   return a - b;
            8'h20:   return a ^ b;
            8'h10:   return a | b;
            8'h08:   return a & b;
            8'h04:   return ~(a | b);
            8'h02:   return ~(a & b);
            default: return ~(a ^ b);
        endcase
    endfunction

    // Datapath model: stage1 computes the result, stage2 produces its parity.
    always @(posedge clk) begin
        dpRes <= aluModel(bus.func_code, bus.a_out, bus.b_out);
        dpPar <= ~^dpRes;
    end

    assign bus.parity_in = dpPar;

    // Stimulus table: op, a, b, tag, and hand-computed parity of the result.
    logic [2:0] stimOp  [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    logic [3:0] stimA   [8] = '{4'd3, 4'd6, 4'd1, 4'd15, 4'd9, 4'd7, 4'd9, 4'd12};
    logic [3:0] stimB   [8] = '{4'd12, 4'd3, 4'd2, 4'd15, 4'd9, 4'd8, 4'd2, 4'd10};
    logic       expPar  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] expFunc [8] = '{8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80, 8'h40, 8'h20};
    int         expCnt  [10] = '{3, 3, 3, 3, 3, 2, 1, 0, 0, 0};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] tag);
        bus.in_valid = vld;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
    endtask

    task automatic applyEntry(input int idx);
        applyStimulus(1'b1, stimOp[idx], stimA[idx], stimB[idx], 4'(idx));
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        bus.issue_en = 1'b0;
        bus.flush    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_func", 32'(bus.func_code), 32'h80);
        checkOutput("rst_resvld", 32'(bus.res_valid), 32'd0);
        rst_n = 1'b1;

        // Single add request: 5+14 -> 0011, odd parity 1.
        applyStimulus(1'b1, 3'd0, 4'd5, 4'd14, 4'd1);
        bus.issue_en = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checkOutput("t2_count_push", 32'(bus.count), 32'd1);
        step();
        checkOutput("t2_func", 32'(bus.func_code), 32'h80);
        checkOutput("t2_a", 32'(bus.a_out), 32'd5);
        checkOutput("t2_b", 32'(bus.b_out), 32'd14);
        checkOutput("t2_count_pop", 32'(bus.count), 32'd0);
        checkOutput("t2_resvld_early", 32'(bus.res_valid), 32'd0);
        step();
        checkOutput("t2_resvld_mid", 32'(bus.res_valid), 32'd0);
        step();
        checkOutput("t2_resvld", 32'(bus.res_valid), 32'd1);
        checkOutput("t2_tag", 32'(bus.res_tag), 32'd1);
        checkOutput("t2_par", 32'(bus.res_parity), 32'd1);

        // Back-to-back sub and xor: 0111 -> 0, 1011 -> 0.
        applyStimulus(1'b1, 3'd1, 4'd5, 4'd14, 4'd2);
        step();
        applyStimulus(1'b1, 3'd2, 4'd5, 4'd14, 4'd3);
        step();
        checkOutput("t3_func_sub", 32'(bus.func_code), 32'h40);
        bus.in_valid = 1'b0;
        step();
        checkOutput("t3_func_xor", 32'(bus.func_code), 32'h20);
        checkOutput("t3_count", 32'(bus.count), 32'd0);
        step();
        checkOutput("t3_resvld0", 32'(bus.res_valid), 32'd1);
        checkOutput("t3_tag0", 32'(bus.res_tag), 32'd2);
        checkOutput("t3_par0", 32'(bus.res_parity), 32'd0);
        step();
        checkOutput("t3_resvld1", 32'(bus.res_valid), 32'd1);
        checkOutput("t3_tag1", 32'(bus.res_tag), 32'd3);
        checkOutput("t3_par1", 32'(bus.res_parity), 32'd0);
        step();
        checkOutput("t3_resvld_end", 32'(bus.res_valid), 32'd0);

        // Stalled: fill the FIFO, fifth request is held off.
        bus.issue_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyEntry(i);
            step();
            checkOutput($sformatf("t4_count%0d", i), 32'(bus.count), (i < 4) ? 32'(i + 1) : 32'd4);
            checkOutput($sformatf("t4_ready%0d", i), 32'(bus.in_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        checkOutput("t4_func_hold", 32'(bus.func_code), 32'h20);
        checkOutput("t4_resvld", 32'(bus.res_valid), 32'd0);

        // Drain while refilling: tags must come back 0..7 in order.
        bus.issue_en = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            if (j == 1) begin
                applyEntry(4);
            end else if (j <= 5) begin
                applyEntry(j + 2);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (j <= 8) begin
                checkOutput($sformatf("t5_func%0d", j), 32'(bus.func_code), 32'(expFunc[j-1]));
            end
            checkOutput($sformatf("t5_count%0d", j), 32'(bus.count), 32'(expCnt[j-1]));
            checkOutput($sformatf("t5_resvld%0d", j), 32'(bus.res_valid), (j >= 3) ? 32'd1 : 32'd0);
            if (j >= 3) begin
                checkOutput($sformatf("t5_tag%0d", j), 32'(bus.res_tag), 32'(j - 3));
                checkOutput($sformatf("t5_par%0d", j), 32'(bus.res_parity), 32'(expPar[j-3]));
            end
        end

        // Flush one cycle after issuing two ops: both results are killed.
        applyEntry(0);
        step();
        applyEntry(1);
        step();
        bus.in_valid = 1'b0;
        step();
        checkOutput("t6_func_pre", 32'(bus.func_code), 32'h08);
        bus.flush = 1'b1;
        applyStimulus(1'b1, 3'd7, 4'd9, 4'd9, 4'hA);
        step();
        bus.flush = 1'b0;
        checkOutput("t6_count_flush", 32'(bus.count), 32'd0);
        checkOutput("t6_resvld_flush", 32'(bus.res_valid), 32'd0);
        checkOutput("t6_func_hold", 32'(bus.func_code), 32'h08);
        step();
        bus.in_valid = 1'b0;
        checkOutput("t6_count_push", 32'(bus.count), 32'd1);
        checkOutput("t6_resvld_killed", 32'(bus.res_valid), 32'd0);
        step();
        checkOutput("t6_func_new", 32'(bus.func_code), 32'h01);
        checkOutput("t6_resvld_a", 32'(bus.res_valid), 32'd0);
        step();
        checkOutput("t6_resvld_b", 32'(bus.res_valid), 32'd0);
        step();
        checkOutput("t6_resvld", 32'(bus.res_valid), 32'd1);
        checkOutput("t6_tag", 32'(bus.res_tag), 32'hA);
        checkOutput("t6_par", 32'(bus.res_parity), 32'd1);

        // Asynchronous reset with a result in flight and an entry queued.
        applyEntry(2);
        step();
        applyEntry(3);
        step();
        bus.in_valid = 1'b0;
        bus.issue_en = 1'b0;
        checkOutput("t1_pre_count", 32'(bus.count), 32'd1);
        checkOutput("t1_pre_func", 32'(bus.func_code), 32'h04);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t1_count", 32'(bus.count), 32'd0);
        checkOutput("t1_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("t1_func", 32'(bus.func_code), 32'h80);
        checkOutput("t1_a", 32'(bus.a_out), 32'd0);
        checkOutput("t1_resvld", 32'(bus.res_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        checkOutput("t1_resvld_after", 32'(bus.res_valid), 32'd0);
        checkOutput("t1_count_after", 32'(bus.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
